cla_pipe_adder: RTL
===================

Name: cla_pipe_adder

Overview:
- Parametrised, 2-stage pipelined carry-lookahead adder/subtractor.
- Generalises the 4-bit lookahead carry network:
  - WIDTH-bit operands.
  - Two-level group lookahead (4-bit groups, then groups of groups).
  - Add/subtract mode.
  - Carry/overflow flags.
  - Valid/ready flow control.
- Sits in the perceptron datapath as the accumulate/bias adder between the multiplier array and the activation stage.

Parameters:
- WIDTH, 16, operand/result width; multiple of 4, legal range 4..64.
- NGRP, WIDTH/4, number of 4-bit lookahead groups. Derived; not overridable.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset; sampled on rising edge of clk.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, block can accept a beat this cycle.
- a, input, WIDTH, operand A (two's complement when signed flags are used).
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in. Ignored when sub=1.
- sub, input, 1, 0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid, output, 1, result beat valid.
- out_ready, input, 1, downstream accepts result.
- sum, output, WIDTH, result.
- cout, output, 1, carry out of bit WIDTH-1. When sub=1, cout=1 means no borrow.
- ovf, output, 1, signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0 at clock edge):
  - s1_valid=0, out_valid=0.
  - sum=0, cout=0, ovf=0.
  - All stage-1 data registers cleared.
  - Reset overrides any simultaneous handshake.
  - A beat in flight is discarded.
- Stage 1 (S1) registers, on accept:
  - Effective operand bx = b ^ {WIDTH{sub}}.
  - Effective carry-in ce = sub ? 1 : cin.
  - Bit g = a & bx; bit p = a ^ bx.
  - Per group k: G[k] and P[k] from the 4-bit lookahead equations.
    - G = g3 | g2p3 | g1p2p3 | g0p1p2p3.
    - P = p0p1p2p3.
- Stage 2 (S2), combinational from S1 registers, registered into the output registers:
  - Group carry-ins C[0]=ce; C[k+1] = G[k] | P[k]&C[k].
  - C must be evaluated by lookahead over blocks of 4 groups, recursively; no bit-level ripple.
  - In-group bit carries use the 4-bit lookahead equations from C[k].
  - sum = p ^ carry vector.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR cout.
- Arithmetic:
  - Modulo 2^WIDTH; no output width growth.
  - sub=1 with cin=1 gives a-b; cin has no effect.
- Flow control:
  - S1 advances when !s1_valid | !out_valid | out_ready.
  - in_ready equals the S1-advance condition (combinational from out_ready).
  - Input accepted when in_valid & in_ready.
  - Output register loads from S1 when s1_valid & (!out_valid | out_ready).
  - out_valid clears when the beat is consumed and S1 holds no valid beat.
- Latency and throughput:
  - Latency: 2 cycles from accept to out_valid with no stall.
  - Throughput: 1 beat/cycle with out_ready held high.
- Stall:
  - While out_valid & !out_ready, sum/cout/ovf hold stable.
  - S1 holds its beat; in_ready=0 when S1 is also full.
  - No beat is lost or duplicated.
- Simultaneous accept and consume in the same cycle is legal; the pipeline shifts with no bubble.
- Order is preserved; there is no reordering or dropping.

Optional Feature:
- Macro: CLA_SAT_EN.
- Defined: signed saturation on overflow.
  - If ovf=1, sum = sign of a' ? {1'b1,{WIDTH-1{0}}} : {1'b0,{WIDTH-1{1}}}.
    - a' is the S1-registered a.
    - For sub, the sign follows a as well.
  - ovf still reports 1; cout is unchanged.
  - Added logic stays inside S2; latency is unchanged.
- Undefined: sum always wraps modulo 2^WIDTH.

Test Plan (WIDTH=16):
- Basic add: a=0x1234, b=0x4321, cin=0, sub=0, out_ready=1.
  - 2 cycles later: sum=0x5555, cout=0, ovf=0.
- Full carry chain: a=0xFFFF, b=0x0000, cin=1.
  - sum=0x0000, cout=1, ovf=0; exercises every group carry.
- Subtract / overflow:
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
  - With CLA_SAT_EN: sum=0x8000, ovf=1.
- Back-to-back with stall:
  - Stream 4 beats, with out_ready=0 for 3 cycles after the first result.
  - in_ready drops once S1 and the output register are full.
  - Results emerge in order, held stable during the stall, with none lost.
- Reset mid-stream:
  - Assert rst_n=0 for 1 cycle with 2 beats in flight.
  - Next cycle: out_valid=0, sum=0, in_ready=1; no stale beat ever appears.
- Randomised: 10k random a/b/cin/sub with random out_ready, against a reference model.
  - Results checked for sum/cout/ovf equality.
  - Repeat at WIDTH=4 and WIDTH=64.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Optional macro CLA_SAT_EN enables signed saturation of the result on overflow.
module cla_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = WIDTH / 4;
  localparam int NBLK = (NGRP + 3) / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (g[2] & p[3]) | (g[1] & p[2] & p[3]) | (g[0] & p[1] & p[2] & p[3]);
  endfunction

  // Sum-of-products lookahead carry out of position n (0..3), no ripple terms.
  function automatic logic la_carry(input logic [3:0] g, input logic [3:0] p,
                                    input logic c0, input int n);
    logic c;
    logic t;
    c = c0;
    for (int m = 0; m < 4; m++) if (m <= n) c &= p[m];
    for (int i = 0; i < 4; i++) begin
      if (i <= n) begin
        t = g[i];
        for (int m = 0; m < 4; m++) if (m > i && m <= n) t &= p[m];
        c |= t;
      end
    end
    return c;
  endfunction

  logic             s1_adv, accept, out_load;
  logic [WIDTH-1:0] bx, g_d, p_d;
  logic [NGRP-1:0]  gg_d, gp_d;
  logic             ce_d;

  logic             s1_valid_q, s1_ce_q;
  logic [WIDTH-1:0] s1_g_q, s1_p_q;
  logic [NGRP-1:0]  s1_gg_q, s1_gp_q;
`ifdef CLA_SAT_EN
  logic             s1_sign_q;
`endif

  assign s1_adv   = !s1_valid_q || !out_valid || out_ready;
  assign in_ready = s1_adv;
  assign accept   = in_valid && s1_adv;
  assign out_load = s1_valid_q && (!out_valid || out_ready);

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    bx   = b ^ {WIDTH{sub}};
    ce_d = sub | cin;
    g_d  = a & bx;
    p_d  = a ^ bx;
    gg_d = '0;
    gp_d = '0;
    for (int k = 0; k < NGRP; k++) begin
      gg_d[k] = grp_gen(g_d[4*k +: 4], p_d[4*k +: 4]);
      gp_d[k] = &p_d[4*k +: 4];
    end
  end

  // NOTE: reset is synchronous and also clears the data registers, so no stale beat can reappear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ce_q    <= 1'b0;
      s1_g_q     <= '0;
      s1_p_q     <= '0;
      s1_gg_q    <= '0;
      s1_gp_q    <= '0;
`ifdef CLA_SAT_EN
      s1_sign_q  <= 1'b0;
`endif
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (accept) begin
        s1_ce_q   <= ce_d;
        s1_g_q    <= g_d;
        s1_p_q    <= p_d;
        s1_gg_q   <= gg_d;
        s1_gp_q   <= gp_d;
`ifdef CLA_SAT_EN
        s1_sign_q <= a[WIDTH-1];
`endif
      end
    end
  end

  logic [4*NBLK-1:0] gg_pad, gp_pad;
  logic [NBLK-1:0]   blk_c;
  logic [NGRP:0]     gc;
  logic [WIDTH:0]    carry;
  logic [WIDTH-1:0]  sum_d;
  logic              cout_d, ovf_d;

  assign gg_pad = (4*NBLK)'(s1_gg_q);
  assign gp_pad = (4*NBLK)'(s1_gp_q);

  // Carries into each block of four groups: second lookahead level.
  if (NBLK > 1) begin : g_blk
    logic [3:0] blk_g, blk_p;
    always_comb begin
      blk_g    = '0;
      blk_p    = '0;
      blk_c    = '0;
      for (int j = 0; j < NBLK - 1; j++) begin
        blk_g[j] = grp_gen(gg_pad[4*j +: 4], gp_pad[4*j +: 4]);
        blk_p[j] = &gp_pad[4*j +: 4];
      end
      blk_c[0] = s1_ce_q;
      for (int j = 1; j < NBLK; j++) blk_c[j] = la_carry(blk_g, blk_p, s1_ce_q, j - 1);
    end
  end else begin : g_noblk
    assign blk_c = s1_ce_q;
  end

  always_comb begin
    gc    = '0;
    carry = '0;
    gc[0] = s1_ce_q;
    for (int k = 0; k < NGRP; k++)
      gc[k+1] = la_carry(gg_pad[4*(k/4) +: 4], gp_pad[4*(k/4) +: 4], blk_c[k/4], k % 4);
    for (int k = 0; k < NGRP; k++)
      for (int i = 0; i < 3; i++)
        carry[4*k+i+1] = la_carry(s1_g_q[4*k +: 4], s1_p_q[4*k +: 4], gc[k], i);
    for (int k = 0; k <= NGRP; k++) carry[4*k] = gc[k];

    sum_d  = s1_p_q ^ carry[WIDTH-1:0];
    cout_d = carry[WIDTH];
    ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
`ifdef CLA_SAT_EN
    if (ovf_d) sum_d = s1_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      sum       <= sum_d;
      cout      <= cout_d;
      ovf       <= ovf_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
